mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Arbitrates a single start/finish memory port between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write). The block sits between the pipeline's fetch and MEM stages and the AXI4 read/write bridge. It latches one request at a time, drives the bridge until the matching finish arrives, and returns read data plus a one-cycle done pulse to the granted requester. The grant alternates whenever both sides contend, so neither requester can starve the other.

## Interface
- TIMEOUT_CYCLES, 1024: bus cycles allowed per transaction before abort. Used only with MEM_ARB_TIMEOUT_EN.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset; synchronous, active-high.
- ifu_req  in  1  IFU read request. Held high until ifu_done.
- ifu_addr  in  64  IFU read address.
- ifu_rdata  out  64  registered read data. Valid while ifu_done=1.
- ifu_done  out  1  one-cycle completion pulse to IFU.
- lsu_req  in  1  LSU request. Held high until lsu_done.
- lsu_we  in  1  1 selects write, 0 selects read.
- lsu_addr  in  64  LSU address.
- lsu_wdata  in  64  LSU write data.
- lsu_wmask  in  8  LSU byte strobe.
- lsu_rdata  out  64  registered read data. Valid while lsu_done=1.
- lsu_done  out  1  one-cycle completion pulse to LSU.
- rd_start  out  1  bridge read request. Level signal, held until rd_finish.
- rd_addr  out  64  latched read address.
- rd_finish  in  1  bridge read complete.
- rd_data  in  64  read data. Valid with rd_finish.
- wr_start  out  1  bridge write request. Level signal, held until wr_finish.
- wr_addr, wr_data  out  64  latched write address and data.
- wr_mask  out  8  latched byte strobe.
- wr_finish  in  1  bridge write complete.
- err  out  1  timeout abort pulse, coincident with done.

## Operation
- States:
  - IDLE: no transaction outstanding.
  - RD_BUSY: read issued to the bridge.
  - WR_BUSY: write issued to the bridge.
  - DONE: one-cycle completion state.
- Registers: owner (0 = IFU, 1 = LSU) and last_grant.
- IDLE, arbitration:
  - Only one requester high: grant that requester.
  - Both high: grant the requester that is NOT last_grant.
  - last_grant resets to IFU, so the LSU wins the first contention.
- IDLE, on grant:
  - Latch address, wdata, wmask and the write/read type into registers.
  - Set owner and last_grant.
  - Go to RD_BUSY (IFU, or LSU with lsu_we=0) or to WR_BUSY (LSU with lsu_we=1).
- RD_BUSY:
  - rd_start=1; wr_start=0.
  - On rd_finish, capture rd_data into the owner's rdata register and go to DONE.
  - wr_finish is ignored.
- WR_BUSY:
  - wr_start=1; rd_start=0.
  - On wr_finish, go to DONE.
  - rd_finish is ignored.
- DONE:
  - Both starts are 0.
  - The owner's done output is 1 for exactly this cycle.
  - Next state is always IDLE.
- Requester inputs are sampled only in IDLE. Changes during BUSY/DONE have no effect on the transaction in flight.
- rdata registers hold their value until the next read completes for the same owner.
- The write path never modifies rdata.

## Timing
- Request latency:
  - A request is sampled in IDLE at edge 0.
  - The start output and latched bus fields are high/valid from cycle 1.
- Completion latency:
  - A finish sampled at edge k drives done (and rdata valid) in cycle k+1.
  - The start output is already 0 in cycle k+1.
- Minimum round trip is 3 cycles (request, busy, done), when finish arrives in the first busy cycle.
- Requesters drop req on the edge that samples done. IDLE follows DONE, so a request still held is re-served as a new transaction.
- Back-to-back contention: IDLE cycles between grants are exactly one. Pattern: DONE → IDLE → BUSY.
- Finish arriving while the block is in IDLE or DONE is ignored.
- Reset, including mid-transaction, gives:
  - state = IDLE, owner = IFU, last_grant = IFU.
  - rd_start = wr_start = 0, ifu_done = lsu_done = 0, err = 0.
  - All rdata and latched bus fields = 0.
  - No done pulse is issued for the aborted transaction.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to RD_BUSY or WR_BUSY and increments each busy cycle.
  - When the count reaches TIMEOUT_CYCLES with no finish, the block goes to DONE.
  - In that DONE cycle: owner's done=1, err=1, and the owner's rdata is forced to 64'h0.
  - A late finish is then ignored under the IDLE/DONE rule.
- MEM_ARB_TIMEOUT_EN not defined:
  - No counter is built; err is tied to 0.
  - The BUSY states wait indefinitely for finish.

## Test plan
- IFU read alone: ifu_req=1, ifu_addr=0x8000_0000, rd_finish 2 cycles after rd_start with rd_data=0x1234 → rd_addr=0x8000_0000 from cycle 1, ifu_done=1 with ifu_rdata=0x1234 in the cycle after rd_finish, lsu_done stays 0.
- LSU write: lsu_req=1, lsu_we=1, lsu_addr=0x8000_0100, lsu_wdata=0xAA55, lsu_wmask=0x0F → wr_start=1, wr_* fields equal to the latched values, rd_start=0 throughout; lsu_done pulses once after wr_finish; lsu_rdata unchanged.
- Contention: both req high from reset, each held until its done → LSU served first, then IFU; grants alternate LSU, IFU, LSU… with exactly one IDLE cycle between transactions.
- Spurious finish: wr_finish pulsed during RD_BUSY, and rd_finish pulsed during IDLE → no state change, no done pulse.
- Reset mid-op: rst asserted in RD_BUSY before rd_finish → next cycle rd_start=0, no done pulse; a later rd_finish is ignored.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): IFU read with no rd_finish → rd_start held 8 cycles, then ifu_done=1, err=1, ifu_rdata=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Arbitrates IFU reads and LSU reads/writes onto one start/finish
//            bridge port, alternating the grant under contention.
//            Optional bus timeout abort is built when MEM_ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
`ifdef MEM_ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 1024
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req,
    input  logic [63:0] ifu_addr,
    output logic [63:0] ifu_rdata,
    output logic        ifu_done,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [63:0] lsu_addr,
    input  logic [63:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic [63:0] lsu_rdata,
    output logic        lsu_done,
    output logic        rd_start,
    output logic [63:0] rd_addr,
    input  logic        rd_finish,
    input  logic [63:0] rd_data,
    output logic        wr_start,
    output logic [63:0] wr_addr,
    output logic [63:0] wr_data,
    output logic [7:0]  wr_mask,
    input  logic        wr_finish,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_BUSY = 2'd1,
        S_WR_BUSY = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state_q;
    logic        owner_q;
    logic        last_grant_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wmask_q;
    logic [63:0] ifu_rdata_q;
    logic [63:0] lsu_rdata_q;
    logic        rd_start_q;
    logic        wr_start_q;
    logic        ifu_done_q;
    logic        lsu_done_q;
    logic        grant_lsu_d;
    logic        timeout_d;

    // Under contention the side that did not win last time gets the bus.
    assign grant_lsu_d = lsu_req & (~ifu_req | ~last_grant_q);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          err_q;

    assign timeout_d = (cnt_q == C_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_RD_BUSY || state_q == S_WR_BUSY) begin
                cnt_q <= cnt_q + CW'(1);
            end else begin
                cnt_q <= '0;
            end
            err_q <= timeout_d & (((state_q == S_RD_BUSY) & ~rd_finish) |
                                  ((state_q == S_WR_BUSY) & ~wr_finish));
        end
    end

    assign err = err_q;
`else
    assign timeout_d = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
            rd_start_q   <= 1'b0;
            wr_start_q   <= 1'b0;
            ifu_done_q   <= 1'b0;
            lsu_done_q   <= 1'b0;
        end else begin
            ifu_done_q <= 1'b0;
            lsu_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ifu_req | lsu_req) begin
                        owner_q      <= grant_lsu_d;
                        last_grant_q <= grant_lsu_d;
                        if (grant_lsu_d) begin
                            addr_q  <= lsu_addr;
                            wdata_q <= lsu_wdata;
                            wmask_q <= lsu_wmask;
                            if (lsu_we) begin
                                wr_start_q <= 1'b1;
                                state_q    <= S_WR_BUSY;
                            end else begin
                                rd_start_q <= 1'b1;
                                state_q    <= S_RD_BUSY;
                            end
                        end else begin
                            addr_q     <= ifu_addr;
                            wdata_q    <= '0;
                            wmask_q    <= '0;
                            rd_start_q <= 1'b1;
                            state_q    <= S_RD_BUSY;
                        end
                    end
                end
                S_RD_BUSY: begin
                    if (rd_finish | timeout_d) begin
                        rd_start_q <= 1'b0;
                        state_q    <= S_DONE;
                        // An aborted read returns zero rather than stale data.
                        if (owner_q) begin
                            lsu_done_q  <= 1'b1;
                            lsu_rdata_q <= rd_finish ? rd_data : '0;
                        end else begin
                            ifu_done_q  <= 1'b1;
                            ifu_rdata_q <= rd_finish ? rd_data : '0;
                        end
                    end
                end
                S_WR_BUSY: begin
                    if (wr_finish | timeout_d) begin
                        wr_start_q <= 1'b0;
                        state_q    <= S_DONE;
                        if (owner_q) begin
                            lsu_done_q <= 1'b1;
                            if (!wr_finish) begin
                                lsu_rdata_q <= '0;
                            end
                        end else begin
                            ifu_done_q <= 1'b1;
                            if (!wr_finish) begin
                                ifu_rdata_q <= '0;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ifu_rdata = ifu_rdata_q;
    assign lsu_rdata = lsu_rdata_q;
    assign ifu_done  = ifu_done_q;
    assign lsu_done  = lsu_done_q;
    assign rd_start  = rd_start_q;
    assign wr_start  = wr_start_q;
    assign rd_addr   = addr_q;
    assign wr_addr   = addr_q;
    assign wr_data   = wdata_q;
    assign wr_mask   = wmask_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Directed scoreboard bench for mem_bus_arbiter; expected completions
//            are queued by the stimulus and popped by a done-pulse monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req, lsu_req, lsu_we, rd_finish, wr_finish;
    logic [63:0] ifu_addr, lsu_addr, lsu_wdata, rd_data;
    logic [7:0]  lsu_wmask;
    logic [63:0] ifu_rdata, lsu_rdata, rd_addr, wr_addr, wr_data;
    logic [7:0]  wr_mask;
    logic        ifu_done, lsu_done, rd_start, wr_start, err;

    typedef struct packed {
        logic        lsu;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [63:0] mon_rdata;
    int          total = 0;
    int          bad   = 0;
    logic [63:0] m_ifu_rdata = '0;
    logic [63:0] m_lsu_rdata = '0;

    always #5 clk = ~clk;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
`else
    mem_bus_arbiter dut (
`endif
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rdata(ifu_rdata), .ifu_done(ifu_done),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_rdata(lsu_rdata), .lsu_done(lsu_done),
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_finish(rd_finish), .rd_data(rd_data),
        .wr_start(wr_start), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_finish(wr_finish), .err(err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Full read transaction; finish is raised lat cycles after the first busy cycle.
    task automatic do_read(input logic lsu, input logic [63:0] addr, input logic [63:0] data,
                           input int lat);
        if (lsu) begin
            lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = addr;
        end else begin
            ifu_req = 1'b1; ifu_addr = addr;
        end
        cyc();
        chk("rd_start_busy", rd_start, 1);
        chk("rd_addr_latched", rd_addr, addr);
        chk("wr_start_in_read", wr_start, 0);
        repeat (lat) cyc();
        rd_finish = 1'b1; rd_data = data;
        if (lsu) m_lsu_rdata = data; else m_ifu_rdata = data;
        sb_q.push_back('{lsu, data, 1'b0});
        cyc();
        rd_finish = 1'b0; ifu_req = 1'b0; lsu_req = 1'b0;
        chk("rd_start_done", rd_start, 0);
        cyc();
    endtask

    // Done-pulse monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (ifu_done || lsu_done)) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_done: got ifu_done=%0b lsu_done=%0b want none",
                         ifu_done, lsu_done);
            end else begin
                mon_e     = sb_q.pop_front();
                mon_rdata = mon_e.lsu ? lsu_rdata : ifu_rdata;
                if ((ifu_done && lsu_done) || lsu_done !== mon_e.lsu ||
                    mon_rdata !== mon_e.rdata || err !== mon_e.err) begin
                    bad++;
                    $display("FAIL sb_done: got lsu=%0b ifu=%0b rdata=%h err=%0b want lsu=%0b rdata=%h err=%0b",
                             lsu_done, ifu_done, mon_rdata, err, mon_e.lsu, mon_e.rdata, mon_e.err);
                end
            end
        end else if (!rst && err) begin
            total++;
            bad++;
            $display("FAIL sb_stray_err: got err=1 want 0");
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        ifu_req = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; rd_finish = 1'b0; wr_finish = 1'b0;
        ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; rd_data = '0;
        repeat (3) cyc();
        chk("rst_rd_start", rd_start, 0);
        chk("rst_wr_start", wr_start, 0);
        chk("rst_dones", {ifu_done, lsu_done, err}, 0);
        chk("rst_ifu_rdata", ifu_rdata, 0);
        chk("rst_rd_addr", rd_addr, 0);
        rst = 1'b0;
        cyc();

        do_read(1'b0, 64'h8000_0000, 64'h1234, 2);
        do_read(1'b1, 64'h8000_0200, 64'hCAFE_F00D_0000_0001, 0);

        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 64'h8000_0100;
        lsu_wdata = 64'hAA55; lsu_wmask = 8'h0F;
        cyc();
        chk("wr_start_busy", wr_start, 1);
        chk("wr_rd_start", rd_start, 0);
        chk("wr_addr", wr_addr, 64'h8000_0100);
        chk("wr_data", wr_data, 64'hAA55);
        chk("wr_mask", wr_mask, 8'h0F);
        cyc();
        chk("wr_rd_start_hold", rd_start, 0);
        wr_finish = 1'b1;
        sb_q.push_back('{1'b1, m_lsu_rdata, 1'b0});
        cyc();
        wr_finish = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0;
        chk("wr_start_done", wr_start, 0);
        cyc();

        ifu_req = 1'b1; ifu_addr = 64'h8000_0300;
        cyc();
        wr_finish = 1'b1;
        cyc();
        wr_finish = 1'b0;
        chk("spur_rd_hold", rd_start, 1);
        rd_finish = 1'b1; rd_data = 64'h5555_6666;
        m_ifu_rdata = 64'h5555_6666;
        sb_q.push_back('{1'b0, 64'h5555_6666, 1'b0});
        cyc();
        rd_finish = 1'b0; ifu_req = 1'b0;
        cyc();
        rd_finish = 1'b1; rd_data = 64'hDEAD;
        cyc();
        rd_finish = 1'b0;
        chk("spur_idle_starts", {rd_start, wr_start}, 0);
        chk("spur_idle_rdata", ifu_rdata, m_ifu_rdata);
        cyc();

`ifdef MEM_ARB_TIMEOUT_EN
        ifu_req = 1'b1; ifu_addr = 64'h8000_0400;
        cyc();
        ifu_req = 1'b0;
        m_ifu_rdata = '0;
        sb_q.push_back('{1'b0, 64'h0, 1'b1});
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (rd_start) n++;
            cyc();
        end
        chk("to_start_cycles", n, 8);
`endif

        ifu_req = 1'b1; ifu_addr = 64'h8000_0500;
        cyc();
        chk("mid_rst_busy", rd_start, 1);
        rst = 1'b1; ifu_req = 1'b0;
        cyc();
        chk("mid_rst_start", rd_start, 0);
        chk("mid_rst_rdata", ifu_rdata, 0);
        chk("mid_rst_addr", rd_addr, 0);
        rst = 1'b0; m_ifu_rdata = '0; m_lsu_rdata = '0;
        rd_finish = 1'b1; rd_data = 64'hBEEF;
        cyc();
        rd_finish = 1'b0;
        cyc();
        chk("mid_rst_late_finish", {rd_start, ifu_rdata}, 0);

        // Both requesters stay asserted; grants must go LSU, IFU, LSU, IFU.
        ifu_addr = 64'h1000; lsu_addr = 64'h2000; lsu_we = 1'b0;
        ifu_req = 1'b1; lsu_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic        exp_lsu;
            logic [63:0] d;
            exp_lsu = (i % 2 == 0);
            d       = 64'hC000 + 64'(i);
            cyc();
            chk("cont_busy", rd_start, 1);
            chk("cont_grant_addr", rd_addr, exp_lsu ? 64'h2000 : 64'h1000);
            rd_finish = 1'b1; rd_data = d;
            sb_q.push_back('{exp_lsu, d, 1'b0});
            cyc();
            rd_finish = 1'b0;
            chk("cont_done_start", rd_start, 0);
            cyc();
            chk("cont_idle_gap", rd_start, 0);
            if (i == 3) begin
                ifu_req = 1'b0; lsu_req = 1'b0;
            end
        end

        repeat (3) cyc();
        chk("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
